mem_access_unit: RTL and testbench

//  Memory-stage consumer of the EX/ME pipeline register: takes me_aluop/me_mem_addr/me_w_* and performs the load or store.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port between the memory stage and the data memory.
// The master drives the request; the slave returns read data with a one-cycle ack strobe.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues loads/stores from EX/ME on a req/ack port, formats load data and
// presents the writeback triple to ME/WB; stalls the pipeline while an access is outstanding.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        me_aluop,
    input  logic [31:0]       me_mem_addr,
    input  logic [31:0]       me_store_data,
    input  logic              me_w_enable,
    input  logic [4:0]        me_w_addr,
    input  logic [31:0]       me_w_data,
    output logic              wb_w_enable,
    output logic [4:0]        wb_w_addr,
    output logic [31:0]       wb_w_data,
    output logic              stall_req,
    mem_access_unit_if.master mem,
    output logic              misalign,
    output logic              bus_err
);
    localparam logic [7:0] EXOP_LB  = 8'h20;
    localparam logic [7:0] EXOP_LH  = 8'h21;
    localparam logic [7:0] EXOP_LW  = 8'h22;
    localparam logic [7:0] EXOP_LBU = 8'h23;
    localparam logic [7:0] EXOP_LHU = 8'h24;
    localparam logic [7:0] EXOP_SB  = 8'h28;
    localparam logic [7:0] EXOP_SH  = 8'h29;
    localparam logic [7:0] EXOP_SW  = 8'h2A;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_result;
    logic        r_misalign;
    logic        r_bus_err;
    logic [7:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_wait;
    logic        r_abort;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_mem_op;
    logic [1:0]  w_lane;
    logic        w_misaligned;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [15:0] w_wait_next;
    logic        w_timeout;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        case (me_aluop)
            EXOP_LB, EXOP_LBU: begin w_is_load = 1'b1;  w_is_byte = 1'b1; end
            EXOP_LH, EXOP_LHU: begin w_is_load = 1'b1;  w_is_half = 1'b1; end
            EXOP_LW:           begin w_is_load = 1'b1;                    end
            EXOP_SB:           begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            EXOP_SH:           begin w_is_store = 1'b1; w_is_half = 1'b1; end
            EXOP_SW:           begin w_is_store = 1'b1;                   end
            default: ;
        endcase
    end

    assign w_mem_op     = w_is_load || w_is_store;
    assign w_lane       = me_mem_addr[1:0];
    assign w_misaligned = w_mem_op && ((w_is_half && w_lane[0]) ||
                          (!w_is_byte && !w_is_half && (w_lane != 2'b00)));
    assign w_start      = (r_state == S_IDLE) && w_mem_op && !w_misaligned;

    always_comb begin
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{me_store_data[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{me_store_data[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = me_store_data;
        end
    end

    // Load formatting uses the op/lane latched at issue, not the live EX/ME inputs.
    always_comb begin
        case (r_lane)
            2'd0:    w_ld_byte = mem.mem_rdata[7:0];
            2'd1:    w_ld_byte = mem.mem_rdata[15:8];
            2'd2:    w_ld_byte = mem.mem_rdata[23:16];
            default: w_ld_byte = mem.mem_rdata[31:24];
        endcase
        w_ld_half = r_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_op)
            EXOP_LB:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            EXOP_LBU: w_ld_data = {24'd0, w_ld_byte};
            EXOP_LH:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            EXOP_LHU: w_ld_data = {16'd0, w_ld_half};
            default:  w_ld_data = mem.mem_rdata;
        endcase
    end

    assign w_wait_next = (r_wait == '1) ? r_wait : r_wait + 16'd1;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (32'(w_wait_next) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_result   <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_op       <= '0;
            r_lane     <= '0;
            r_wait     <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_misaligned) begin
                        r_misalign <= 1'b1;
                    end else if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {me_mem_addr[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_op    <= me_aluop;
                        r_lane  <= w_lane;
                        r_wait  <= '0;
                        r_abort <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ack) begin
                        r_req    <= 1'b0;
                        r_result <= w_ld_data;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_abort   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait <= w_wait_next;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wb_w_enable = 1'b0;
        wb_w_addr   = '0;
        wb_w_data   = '0;
        stall_req   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_mem_op) begin
                        wb_w_enable = me_w_enable;
                        wb_w_addr   = me_w_addr;
                        wb_w_data   = me_w_data;
                    end else if (w_misaligned) begin
                        wb_w_addr = me_w_addr;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                S_BUSY: stall_req = 1'b1;
                S_DONE: begin
                    wb_w_addr   = me_w_addr;
                    wb_w_enable = me_w_enable && !r_we && !r_abort;
                    wb_w_data   = r_result;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;
    assign misalign      = r_misalign;
    assign bus_err       = r_bus_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one wait-forever instance and one with a 4-cycle timeout,
// both fed from the same EX/ME stimulus; each has its own memory port.
module tb_mem_access_unit;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h22;
    localparam logic [7:0] OP_LBU = 8'h23;
    localparam logic [7:0] OP_LHU = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned dly;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst1;
    logic [7:0]  me_aluop;
    logic [31:0] me_mem_addr;
    logic [31:0] me_store_data;
    logic        me_w_enable;
    logic [4:0]  me_w_addr;
    logic [31:0] me_w_data;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        stall0, stall1, mis0, mis1, berr0, berr1;
    int          checks = 0;
    int          failures = 0;

    mem_access_unit_if bus0 ();
    mem_access_unit_if bus1 ();

    always #5 clk = ~clk;

    mem_access_unit u_dut0 (
        .clk(clk), .rst(rst), .me_aluop(me_aluop), .me_mem_addr(me_mem_addr),
        .me_store_data(me_store_data), .me_w_enable(me_w_enable), .me_w_addr(me_w_addr),
        .me_w_data(me_w_data), .wb_w_enable(wb0_en), .wb_w_addr(wb0_addr), .wb_w_data(wb0_data),
        .stall_req(stall0), .mem(bus0.master), .misalign(mis0), .bus_err(berr0)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst1), .me_aluop(me_aluop), .me_mem_addr(me_mem_addr),
        .me_store_data(me_store_data), .me_w_enable(me_w_enable), .me_w_addr(me_w_addr),
        .me_w_data(me_w_data), .wb_w_enable(wb1_en), .wb_w_addr(wb1_addr), .wb_w_data(wb1_data),
        .stall_req(stall1), .mem(bus1.master), .misalign(mis1), .bus_err(berr1)
    );

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
        me_aluop      = op;
        me_mem_addr   = addr;
        me_store_data = sdata;
        me_w_enable   = wen;
        me_w_addr     = waddr;
        me_w_data     = wdata;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        rst1 = 1'b1;
        bus0.mem_ack = 1'b0; bus0.mem_rdata = '0;
        bus1.mem_ack = 1'b0; bus1.mem_rdata = '0;
        set_op(OP_LW, 32'h100, 32'h5555, 1'b1, 5'd7, 32'h99);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({wb0_en, wb0_addr, wb0_data} !== 38'd0) begin
            failures++; $display("FAIL rst_wb got=%h exp=0", {wb0_en, wb0_addr, wb0_data});
        end
        checks++;
        if ({stall0, bus0.mem_req, bus0.mem_we, mis0, berr0} !== 5'b0) begin
            failures++; $display("FAIL rst_ctl got=%b exp=00000", {stall0, bus0.mem_req, bus0.mem_we, mis0, berr0});
        end
        checks++;
        if ({bus0.mem_addr, bus0.mem_wdata, bus0.mem_be} !== 68'd0) begin
            failures++; $display("FAIL rst_bus got=%h exp=0", {bus0.mem_addr, bus0.mem_wdata, bus0.mem_be});
        end
        checks++;
        if ({stall1, bus1.mem_req, berr1, wb1_en} !== 4'b0) begin
            failures++; $display("FAIL rst_dut1 got=%b exp=0000", {stall1, bus1.mem_req, berr1, wb1_en});
        end
        rst = 1'b0;
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_passthrough;
        @(negedge clk);
        set_op(OP_ADD, 32'h104, 32'h0, 1'b1, 5'd3, 32'h1234);
        #1;
        checks++;
        if ({wb0_en, wb0_addr, wb0_data, stall0} !== {1'b1, 5'd3, 32'h1234, 1'b0}) begin
            failures++; $display("FAIL pass_wb got=%h exp=%h", {wb0_en, wb0_addr, wb0_data, stall0}, {1'b1, 5'd3, 32'h1234, 1'b0});
        end
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus0.mem_req, stall0, wb0_data} !== {2'b00, 32'h1234}) begin
                failures++; $display("FAIL pass_hold got=%h exp=%h", {bus0.mem_req, stall0, wb0_data}, {2'b00, 32'h1234});
            end
        end
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_loads;
        vec_t t [6];
        int   nstall;
        t = '{
            '{OP_LB,  32'h103, 32'h80FF_0000, 3, 4'b1000, 32'hFFFF_FF80},
            '{OP_LHU, 32'h102, 32'hBEEF_1234, 1, 4'b1100, 32'h0000_BEEF},
            '{OP_LH,  32'h102, 32'hBEEF_1234, 1, 4'b1100, 32'hFFFF_BEEF},
            '{OP_LBU, 32'h101, 32'h0000_A500, 2, 4'b0010, 32'h0000_00A5},
            '{OP_LW,  32'h104, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF},
            '{OP_LB,  32'h200, 32'h0000_007F, 2, 4'b0001, 32'h0000_007F}
        };
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(t[i].op, t[i].addr, 32'h0, 1'b1, 5'(i + 1), 32'h0BAD_0000);
            bus0.mem_rdata = t[i].data;
            #1;
            nstall = stall0 ? 1 : 0;
            checks++;
            if ({bus0.mem_req, wb0_en} !== 2'b00) begin
                failures++; $display("FAIL ld_issue[%0d] got=%b exp=00", i, {bus0.mem_req, wb0_en});
            end
            for (int unsigned k = 1; k <= t[i].dly; k++) begin
                @(negedge clk);
                if (stall0) nstall++;
                checks++;
                if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr} !== {1'b1, 1'b0, t[i].be, t[i].addr & ~32'h3}) begin
                    failures++; $display("FAIL ld_bus[%0d] got=%h exp=%h", i, {bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr}, {1'b1, 1'b0, t[i].be, t[i].addr & ~32'h3});
                end
                if (k == t[i].dly) bus0.mem_ack = 1'b1;
            end
            @(negedge clk);
            bus0.mem_ack = 1'b0;
            #1;
            if (stall0) nstall++;
            checks++;
            if (nstall != int'(t[i].dly) + 1) begin
                failures++; $display("FAIL ld_stall[%0d] got=%0d exp=%0d", i, nstall, t[i].dly + 1);
            end
            checks++;
            if ({wb0_en, wb0_addr, wb0_data, bus0.mem_req} !== {1'b1, 5'(i + 1), t[i].exp, 1'b0}) begin
                failures++; $display("FAIL ld_wb[%0d] got=%h exp=%h", i, {wb0_en, wb0_addr, wb0_data, bus0.mem_req}, {1'b1, 5'(i + 1), t[i].exp, 1'b0});
            end
            set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
    endtask

    task automatic test_stores;
        vec_t t [3];
        t = '{
            '{OP_SH, 32'h22, 32'hAAAA_5678, 2, 4'b1100, 32'h5678_5678},
            '{OP_SB, 32'h31, 32'h1234_56C3, 1, 4'b0010, 32'hC3C3_C3C3},
            '{OP_SW, 32'h40, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D}
        };
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(t[i].op, t[i].addr, t[i].data, 1'b1, 5'd9, 32'h0);
            #1;
            checks++;
            if (stall0 !== 1'b1) begin
                failures++; $display("FAIL st_stall[%0d] got=%b exp=1", i, stall0);
            end
            for (int unsigned k = 1; k <= t[i].dly; k++) begin
                @(negedge clk);
                checks++;
                if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata} !== {1'b1, 1'b1, t[i].be, t[i].addr & ~32'h3, t[i].exp}) begin
                    failures++; $display("FAIL st_bus[%0d] got=%h exp=%h", i, {bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata}, {1'b1, 1'b1, t[i].be, t[i].addr & ~32'h3, t[i].exp});
                end
                if (k == t[i].dly) bus0.mem_ack = 1'b1;
            end
            @(negedge clk);
            bus0.mem_ack = 1'b0;
            #1;
            checks++;
            if ({wb0_en, stall0, bus0.mem_req} !== 3'b000) begin
                failures++; $display("FAIL st_done[%0d] got=%b exp=000", i, {wb0_en, stall0, bus0.mem_req});
            end
            set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
    endtask

    task automatic test_misalign;
        logic [7:0]  ops [5];
        logic [31:0] adr [5];
        ops = '{OP_LW, OP_LH, OP_LW, OP_SW, OP_SH};
        adr = '{32'h101, 32'h103, 32'h102, 32'h203, 32'h11};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_op(ops[i], adr[i], 32'hFFFF_FFFF, 1'b1, 5'd12, 32'h55);
            #1;
            checks++;
            if ({stall0, wb0_en, bus0.mem_req, mis0} !== 4'b0000) begin
                failures++; $display("FAIL mis_comb[%0d] got=%b exp=0000", i, {stall0, wb0_en, bus0.mem_req, mis0});
            end
            @(negedge clk);
            checks++;
            if ({mis0, bus0.mem_req, stall0} !== 3'b100) begin
                failures++; $display("FAIL mis_pulse[%0d] got=%b exp=100", i, {mis0, bus0.mem_req, stall0});
            end
            set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            checks++;
            if (mis0 !== 1'b0) begin
                failures++; $display("FAIL mis_end[%0d] got=%b exp=0", i, mis0);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_op(OP_LW, 32'h10, 32'h0, 1'b1, 5'd2, 32'h0);
        bus0.mem_rdata = 32'h0A0B_0C0D;
        @(negedge clk);
        bus0.mem_ack = 1'b1;
        @(negedge clk);
        bus0.mem_ack = 1'b0;
        #1;
        checks++;
        if ({wb0_en, wb0_addr, wb0_data} !== {1'b1, 5'd2, 32'h0A0B_0C0D}) begin
            failures++; $display("FAIL b2b_ld got=%h exp=%h", {wb0_en, wb0_addr, wb0_data}, {1'b1, 5'd2, 32'h0A0B_0C0D});
        end
        set_op(OP_SB, 32'h13, 32'h0000_00EE, 1'b1, 5'd6, 32'h0);
        @(posedge clk);
        #1;
        checks++;
        if ({stall0, bus0.mem_req} !== 2'b10) begin
            failures++; $display("FAIL b2b_idle got=%b exp=10", {stall0, bus0.mem_req});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata} !== {2'b11, 4'b1000, 32'h10, 32'hEEEE_EEEE}) begin
            failures++; $display("FAIL b2b_st got=%h exp=%h", {bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata}, {2'b11, 4'b1000, 32'h10, 32'hEEEE_EEEE});
        end
        bus0.mem_ack = 1'b1;
        @(negedge clk);
        bus0.mem_ack = 1'b0;
        #1;
        checks++;
        if ({wb0_en, stall0} !== 2'b00) begin
            failures++; $display("FAIL b2b_done got=%b exp=00", {wb0_en, stall0});
        end
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_timeout;
        @(negedge clk);
        rst1 = 1'b0;
        bus1.mem_ack = 1'b0;
        set_op(OP_LW, 32'h80, 32'h0, 1'b1, 5'd9, 32'h0);
        for (int unsigned k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus1.mem_req, stall1, berr1} !== 3'b110) begin
                failures++; $display("FAIL to_busy[%0d] got=%b exp=110", k, {bus1.mem_req, stall1, berr1});
            end
        end
        @(negedge clk);
        checks++;
        if ({bus1.mem_req, stall1, berr1, wb1_en} !== 4'b0010) begin
            failures++; $display("FAIL to_abort got=%b exp=0010", {bus1.mem_req, stall1, berr1, wb1_en});
        end
        @(negedge clk);
        checks++;
        if ({berr1, bus1.mem_req} !== 2'b00) begin
            failures++; $display("FAIL to_pulse got=%b exp=00", {berr1, bus1.mem_req});
        end
        rst1 = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if ({bus0.mem_req, stall0, berr0} !== 3'b110) begin
            failures++; $display("FAIL to_forever got=%b exp=110", {bus0.mem_req, stall0, berr0});
        end
        bus0.mem_rdata = 32'h1122_3344;
        bus0.mem_ack   = 1'b1;
        @(negedge clk);
        bus0.mem_ack = 1'b0;
        #1;
        checks++;
        if ({wb0_en, wb0_addr, wb0_data} !== {1'b1, 5'd9, 32'h1122_3344}) begin
            failures++; $display("FAIL to_late_ack got=%h exp=%h", {wb0_en, wb0_addr, wb0_data}, {1'b1, 5'd9, 32'h1122_3344});
        end
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        set_op(OP_LW, 32'h44, 32'h0, 1'b1, 5'd4, 32'h77);
        @(negedge clk);
        checks++;
        if (bus0.mem_req !== 1'b1) begin
            failures++; $display("FAIL rb_busy got=%b exp=1", bus0.mem_req);
        end
        rst = 1'b1;
        bus0.mem_rdata = 32'hFFFF_FFFF;
        bus0.mem_ack   = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus0.mem_req, stall0, wb0_en} !== 3'b000) begin
            failures++; $display("FAIL rb_drop got=%b exp=000", {bus0.mem_req, stall0, wb0_en});
        end
        rst = 1'b0;
        bus0.mem_ack = 1'b0;
        set_op(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd4, 32'h77);
        #1;
        checks++;
        if ({wb0_en, wb0_addr, wb0_data, stall0} !== {1'b1, 5'd4, 32'h77, 1'b0}) begin
            failures++; $display("FAIL rb_idle got=%h exp=%h", {wb0_en, wb0_addr, wb0_data, stall0}, {1'b1, 5'd4, 32'h77, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({bus0.mem_req, wb0_data} !== {1'b0, 32'h77}) begin
            failures++; $display("FAIL rb_after got=%h exp=%h", {bus0.mem_req, wb0_data}, {1'b0, 32'h77});
        end
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_misalign();
        test_back_to_back();
        test_timeout();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
